stream_buffer: RTL
==================

STREAM_BUFFER -- requirements
Module: stream_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, total word capacity (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous discard of all stored words.
REQ-006 SHALL have port in_valid  input  1  upstream word present.
REQ-007 SHALL have port in_data  input  DATA_W  upstream word.
REQ-008 SHALL have port in_ready  output  1  buffer accepts a word this cycle.
REQ-009 SHALL have port out_valid  output  1  word presented downstream.
REQ-010 SHALL have port out_data  output  DATA_W  presented word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts presented word.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  words currently held.
REQ-013 SHALL have ports full, empty  output  1 each  count==DEPTH / count==0.

Function
REQ-014 SHALL push when in_valid && in_ready, and pop when out_valid && out_ready, in the same rising edge.
REQ-015 SHALL drive in_ready = !full, from registered state only, with no combinational path from out_ready.
REQ-016 SHALL drive out_valid and out_data from registers, with no combinational path from in_valid or in_data.
REQ-017 SHALL present a word pushed at edge N into an empty buffer with out_valid=1 after edge N (1-cycle latency).
REQ-018 SHALL deliver words in strict FIFO order with no loss or duplication.
REQ-019 SHALL ignore in_valid while full; push and pop in the same cycle when full SHALL pop only, leaving count DEPTH-1.
REQ-020 SHALL push and pop in the same cycle when 0<count<DEPTH, leaving count unchanged.
REQ-021 SHALL perform no pop while empty; out_ready SHALL be ignored.
REQ-022 SHALL wrap internal read/write pointers modulo DEPTH with no gap or bubble at wrap.
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL retain the last presented out_data value while out_valid=0.
REQ-025 SHALL update count as count + push - pop, never exceeding DEPTH and never going below 0.
REQ-026 SHALL, on flush, set count=0, empty=1 and out_valid=0 after the edge; flush overrides push and pop that cycle; out_data is not cleared.

Reset
REQ-027 SHALL, on rst high at an edge, set count=0, out_valid=0, out_data=0, full=0, empty=1, in_ready=1 and both pointers=0.
REQ-028 SHALL give rst priority over flush, push and pop; a reset mid-stream discards all stored words.
REQ-029 SHALL leave storage array contents uninitialised by reset, since they are never observable.

Structure
REQ-030 SHALL place default DATA_W and DEPTH constants and the count-width helper function in package stream_buffer_pkg.
REQ-031 SHALL implement storage as sub-module stream_buffer_mem (DEPTH x DATA_W register array, one write port, one read port); pointer, count and handshake logic stay in stream_buffer.
REQ-032 SHALL include assertions, disabled in synthesis, for: no push when full, no pop when empty, count<=DEPTH, and out_data stable under backpressure.

Verification
REQ-033 SHALL cover: after reset, push 0xA5 at edge 1 -> out_valid=1, out_data=0xA5 after edge 1, count=1.
REQ-034 SHALL cover: out_ready=0, push 0x01..0x04 (DEPTH=4) -> full=1, in_ready=0; a 5th word 0x05 is dropped; draining yields 0x01,0x02,0x03,0x04.
REQ-035 SHALL cover: full, push 0x10 and pop in the same cycle -> count=3, 0x10 is not stored.
REQ-036 SHALL cover: continuous push/pop of 0x00..0x0F with out_ready=1 -> output in the same order, one word per cycle, pointers wrap with no bubble.
REQ-037 SHALL cover: count=2, assert flush together with in_valid=1 -> count=0 and out_valid=0 after the edge; the next push appears 1 cycle later.
REQ-038 SHALL cover: rst asserted with count=3 -> all outputs at reset values after the edge, and no stale word appears afterwards.

Source files
------------

// File: rtl/stream_buffer_pkg.sv
// stream_buffer_pkg: shared defaults and sizing helper for the stream buffer.
//   DEFAULT_DATA_W / DEFAULT_DEPTH : default word width and capacity
//   count_w(depth)                 : width needed to hold 0..depth inclusive
package stream_buffer_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 4;

  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_buffer_mem.sv
// stream_buffer_mem: DEPTH x DATA_W register array, one synchronous write
// port and one asynchronous read port. Contents are not reset.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write word
//   rd_addr : read address
//   rd_data : word stored at rd_addr
module stream_buffer_mem
  import stream_buffer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_buffer.sv
// stream_buffer: ready/valid FIFO with registered output word.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : discard all stored words
//   in_valid / in_data / in_ready    : upstream handshake
//   out_valid / out_data / out_ready : downstream handshake
//   count     : words held (including the presented one)
//   full, empty : count==DEPTH / count==0
module stream_buffer
  import stream_buffer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [count_w(DEPTH)-1:0]  count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [AW-1:0]     wr_ptr, rd_ptr, rd_next;
  logic              push, pop;
  logic [CW-1:0]     count_next;
  logic [DATA_W-1:0] mem_rd_data;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign rd_next    = rd_ptr + AW'(1);
  assign count_next = count + CW'(push) - CW'(pop);

  // The head word is always also in the array; the read port looks one
  // entry ahead so the next head is ready to load when the current pops.
  stream_buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push && !rst && !flush),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_next),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      // Next head: from the array if a second word is stored, otherwise the
      // incoming word bypasses straight into the output register.
      if (pop && (count > CW'(1)))
        out_data <= mem_rd_data;
      else if (push && (empty || pop))
        out_data <= in_data;
    end
  end

`ifndef SYNTHESIS
  logic              stall_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    stall_q <= !rst && out_valid && !out_ready;
    data_q  <= out_data;
    if (!rst) begin
      assert (!(push && full));
      assert (!(pop && empty));
      assert (count <= CW'(DEPTH));
      if (stall_q) assert (out_data == data_q);
    end
  end
`endif

endmodule
